// File: rtl/encoder83_pkg.sv
// ----------------------------------------------------------------------------
// encoder83_pkg
// Shared constants and types for the encoder83_irq block.
//   NUM_REQ    : number of event request lines
//   IDX_W      : width of an event index
//   RR_PTR_RST : reset value of the round-robin search pointer (also the fixed
//                search start when round-robin is not built in)
//   state_e    : presentation FSM states
//   idx_onehot : index -> one-hot mask helper
// ----------------------------------------------------------------------------
package encoder83_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    localparam logic [IDX_W-1:0] RR_PTR_RST = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] one;
        one = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/encoder83_irq_if.sv
// ----------------------------------------------------------------------------
// encoder83_irq_if
// Bundles the event inputs and the valid/ready presentation outputs.
//   req_n  : active-low asynchronous event lines (producer -> block)
//   en_n   : active-low enable                   (producer -> block)
//   ready  : consumer accept                     (consumer -> block)
//   valid  : code holds an unacknowledged event  (block -> consumer)
//   code   : index of the presented event        (block -> consumer)
//   any_n  : low while any event is pending      (block -> consumer)
//   pend   : pending-event register              (block -> consumer)
//   ovf    : one-cycle pulse on a lost event     (block -> consumer)
// Modports: slave = the encoder block, master = its environment.
// ----------------------------------------------------------------------------
interface encoder83_irq_if;
    import encoder83_pkg::*;

    logic [NUM_REQ-1:0] req_n;
    logic               en_n;
    logic               ready;
    logic               valid;
    logic [IDX_W-1:0]   code;
    logic               any_n;
    logic [NUM_REQ-1:0] pend;
    logic               ovf;

    modport slave (
        input  req_n, en_n, ready,
        output valid, code, any_n, pend, ovf
    );

    modport master (
        output req_n, en_n, ready,
        input  valid, code, any_n, pend, ovf
    );

endinterface

// File: rtl/encoder83_irq_prio_enc8.sv
// ----------------------------------------------------------------------------
// prio_enc8
// Combinational downward search with wrap over an 8-bit mask.
//   mask  : candidate bits
//   start : first index examined; search continues start-1, start-2, ... mod 8
//   found : at least one mask bit set
//   idx   : first set index met by the search (start when nothing found)
// With start tied to 7 this is a plain highest-index-wins priority encoder.
// ----------------------------------------------------------------------------
module prio_enc8
    import encoder83_pkg::*;
(
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest distance to the nearest so the candidate closest
    // to start (distance 0) is the last assignment and therefore wins.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = start - IDX_W'(k);
            if (mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/encoder83_irq.sv
// ----------------------------------------------------------------------------
// encoder83_irq
// Eight asynchronous active-low event lines are synchronized, falling edges
// are latched into a pending register, and pending events are presented one
// at a time on a valid/ready handshake.
//   clk         : single clock, all state on its rising edge
//   rst         : asynchronous active-high reset
//   bus (slave) : req_n, en_n, ready in; valid, code, any_n, pend, ovf out
// Parameter SYNC_STAGES : synchronizer flops per request line (1..3).
// Build option ENCODER83_ROUND_ROBIN_EN : after accepting index k the next
// search starts at k-1 and wraps downward; otherwise fixed priority (7 high).
// ----------------------------------------------------------------------------
module encoder83_irq
    import encoder83_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    encoder83_irq_if.slave  bus
);

    // ---------------- synchronizer + edge-history ----------------
    logic [SYNC_STAGES-1:0][NUM_REQ-1:0] sync_q, sync_d;
    logic [NUM_REQ-1:0]                  hist_q, hist_d;
    logic [NUM_REQ-1:0]                  fall;

    // Warm-up shift register: lines already low when reset is released would
    // look like falling edges against the idle-high reset value of the chain.
    // Edges are ignored until the chain and history flop have been refilled
    // from the real pins.
    logic [SYNC_STAGES:0] warm_q, warm_d;
    logic                 armed;

    always_comb begin
        sync_d[0] = bus.req_n;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        hist_d = sync_q[SYNC_STAGES-1];
        warm_d = {warm_q[SYNC_STAGES-1:0], 1'b1};
    end

    assign armed = warm_q[SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_edge
            assign fall[gi] = hist_q[gi] & ~sync_q[SYNC_STAGES-1][gi];
        end
    endgenerate

    // ---------------- pending register / handshake ----------------
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   code_q, code_d;
    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic               ovf_q, ovf_d;

    logic [NUM_REQ-1:0] set_mask;
    logic [NUM_REQ-1:0] clr_mask;
    logic [NUM_REQ-1:0] remain;
    logic               accept;

    logic [NUM_REQ-1:0] srch_mask;
    logic [IDX_W-1:0]   srch_start;
    logic               srch_found;
    logic [IDX_W-1:0]   srch_idx;

    always_comb begin
        accept   = (state_q == ST_HOLD) && bus.ready;
        set_mask = (armed && !bus.en_n) ? fall : '0;
        clr_mask = accept ? idx_onehot(code_q) : '0;
        remain   = pend_q & ~clr_mask;
        // Set wins over a same-edge clear because it is OR-ed in last.
        pend_d   = remain | set_mask;
        // A bit being cleared this edge is not "already pending" for overflow.
        ovf_d    = |(set_mask & remain);
        // In HOLD the only search that matters is the one at an accept, over
        // the bits left once the accepted one is removed.
        srch_mask = (state_q == ST_HOLD) ? remain : pend_q;
    end

`ifdef ENCODER83_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = accept ? (code_q - 3'd1) : ptr_q;
        // At an accept the pointer has not moved yet, so derive the start
        // directly from the index being accepted.
        srch_start = (state_q == ST_HOLD) ? (code_q - 3'd1) : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= RR_PTR_RST;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign srch_start = RR_PTR_RST;
`endif

    prio_enc8 u_prio (
        .mask  (srch_mask),
        .start (srch_start),
        .found (srch_found),
        .idx   (srch_idx)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.en_n && srch_found) begin
                    state_d = ST_HOLD;
                    code_d  = srch_idx;
                end
            end
            ST_HOLD: begin
                // en_n only matters at the accept: the current event is
                // always completed, but no follow-on event is chained.
                if (accept) begin
                    if (!bus.en_n && srch_found) begin
                        code_d = srch_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            hist_q  <= '1;
            warm_q  <= '0;
            state_q <= ST_IDLE;
            code_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            warm_q  <= warm_d;
            state_q <= state_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.valid = (state_q == ST_HOLD);
    assign bus.code  = code_q;
    assign bus.pend  = pend_q;
    assign bus.any_n = ~|pend_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_encoder83_irq.sv
// ----------------------------------------------------------------------------
// tb_encoder83_irq
// Directed stimulus for encoder83_irq with SYNC_STAGES=2. Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_encoder83_irq;
    import encoder83_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    encoder83_irq_if bus ();

    encoder83_irq #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %-22s observed=%02h expected=%02h", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    logic [7:0] rr_first;
    logic [7:0] rr_second;

    initial begin
        total  = 0;
        passed = 0;
`ifdef ENCODER83_ROUND_ROBIN_EN
        rr_first  = 8'd2;
        rr_second = 8'd7;
`else
        rr_first  = 8'd7;
        rr_second = 8'd2;
`endif
        rst       = 1'b1;
        bus.req_n = 8'hFF;
        bus.en_n  = 1'b0;
        bus.ready = 1'b0;

        // Reset state
        #3;
        chk("rst_valid", {7'd0, bus.valid}, 8'd0);
        chk("rst_code",  {5'd0, bus.code},  8'd0);
        chk("rst_pend",  bus.pend,          8'h00);
        chk("rst_any_n", {7'd0, bus.any_n}, 8'd1);
        chk("rst_ovf",   {7'd0, bus.ovf},   8'd0);
        step(2);
        rst = 1'b0;
        step(5);

        // Single event on bit 5 with ready held high
        bus.ready    = 1'b1;
        bus.req_n[5] = 1'b0;
        step(2);
        chk("b5_pend_early", bus.pend, 8'h00);
        step(1);
        chk("b5_pend",       bus.pend, 8'h20);
        chk("b5_any_n",      {7'd0, bus.any_n}, 8'd0);
        chk("b5_valid_pre",  {7'd0, bus.valid}, 8'd0);
        step(1);
        chk("b5_valid",      {7'd0, bus.valid}, 8'd1);
        chk("b5_code",       {5'd0, bus.code},  8'd5);
        step(1);
        chk("b5_valid_post", {7'd0, bus.valid}, 8'd0);
        chk("b5_pend_post",  bus.pend, 8'h00);
        chk("b5_any_n_post", {7'd0, bus.any_n}, 8'd1);
        bus.req_n[5] = 1'b1;
        bus.ready    = 1'b0;
        step(4);

        // Bits 1 and 6 together, consumer stalls then accepts back to back
        bus.req_n[1] = 1'b0;
        bus.req_n[6] = 1'b0;
        step(3);
        chk("b16_pend", bus.pend, 8'h42);
        step(1);
        chk("b16_valid", {7'd0, bus.valid}, 8'd1);
        chk("b16_code",  {5'd0, bus.code},  8'd6);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("b16_code_stall", {5'd0, bus.code}, 8'd6);
        end
        bus.ready = 1'b1;
        step(1);
        chk("b16_nobubble_valid", {7'd0, bus.valid}, 8'd1);
        chk("b16_next_code",      {5'd0, bus.code},  8'd1);
        chk("b16_pend_mid",       bus.pend, 8'h02);
        step(1);
        chk("b16_idle_valid", {7'd0, bus.valid}, 8'd0);
        chk("b16_idle_pend",  bus.pend, 8'h00);
        bus.ready    = 1'b0;
        bus.req_n[1] = 1'b1;
        bus.req_n[6] = 1'b1;
        step(4);

        // Second falling edge on a still-pending bit 3 -> overflow pulse
        bus.req_n[3] = 1'b0;
        step(4);
        chk("b3_code", {5'd0, bus.code}, 8'd3);
        bus.req_n[3] = 1'b1;
        step(3);
        bus.req_n[3] = 1'b0;
        step(2);
        chk("b3_ovf_before", {7'd0, bus.ovf}, 8'd0);
        step(1);
        chk("b3_ovf_pulse",  {7'd0, bus.ovf}, 8'd1);
        chk("b3_pend_keep",  bus.pend, 8'h08);
        step(1);
        chk("b3_ovf_after",  {7'd0, bus.ovf}, 8'd0);
        chk("b3_valid_keep", {7'd0, bus.valid}, 8'd1);
        bus.ready = 1'b1;
        step(1);
        chk("b3_accept_pend", bus.pend, 8'h00);
        bus.ready    = 1'b0;
        bus.req_n[3] = 1'b1;
        step(4);

        // Enable gating on bit 2
        bus.en_n     = 1'b1;
        bus.req_n[2] = 1'b0;
        step(4);
        chk("en_block_pend",  bus.pend, 8'h00);
        chk("en_block_valid", {7'd0, bus.valid}, 8'd0);
        bus.req_n[2] = 1'b1;
        step(4);
        bus.en_n     = 1'b0;
        bus.req_n[2] = 1'b0;
        step(3);
        bus.en_n = 1'b1;
        chk("en_pend_set", bus.pend, 8'h04);
        step(2);
        chk("en_hold_idle", {7'd0, bus.valid}, 8'd0);
        bus.en_n = 1'b0;
        step(1);
        chk("en_valid", {7'd0, bus.valid}, 8'd1);
        chk("en_code",  {5'd0, bus.code},  8'd2);
        bus.en_n = 1'b1;
        step(1);
        chk("en_rise_keeps_valid", {7'd0, bus.valid}, 8'd1);
        bus.ready = 1'b1;
        step(1);
        chk("en_accept_valid", {7'd0, bus.valid}, 8'd0);
        chk("en_accept_pend",  bus.pend, 8'h00);
        bus.ready    = 1'b0;
        bus.en_n     = 1'b0;
        bus.req_n[2] = 1'b1;
        step(4);

        // Asynchronous reset while presenting bit 4
        bus.req_n[4] = 1'b0;
        step(4);
        chk("b4_code", {5'd0, bus.code}, 8'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {7'd0, bus.valid}, 8'd0);
        chk("arst_pend",  bus.pend, 8'h00);
        chk("arst_any_n", {7'd0, bus.any_n}, 8'd1);
        chk("arst_code",  {5'd0, bus.code},  8'd0);
        step(1);
        rst = 1'b0;
        step(6);
        chk("held_low_pend",  bus.pend, 8'h00);
        chk("held_low_valid", {7'd0, bus.valid}, 8'd0);
        bus.req_n[4] = 1'b1;
        step(4);

        // Search order: bits 7,5,2 pending, bit 7 re-pends while 5 is shown
        bus.req_n[7] = 1'b0;
        bus.req_n[5] = 1'b0;
        bus.req_n[2] = 1'b0;
        step(3);
        chk("ord_pend", bus.pend, 8'hA4);
        step(1);
        chk("ord_code7", {5'd0, bus.code}, 8'd7);
        bus.ready = 1'b1;
        step(1);
        chk("ord_code5", {5'd0, bus.code}, 8'd5);
        chk("ord_pend5", bus.pend, 8'h24);
        bus.ready    = 1'b0;
        bus.req_n[7] = 1'b1;
        step(3);
        bus.req_n[7] = 1'b0;
        step(3);
        chk("ord_repend", bus.pend, 8'hA4);
        chk("ord_code5_hold", {5'd0, bus.code}, 8'd5);
        bus.ready = 1'b1;
        step(1);
        chk("ord_after5", {5'd0, bus.code}, rr_first);
        step(1);
        chk("ord_after_next", {5'd0, bus.code}, rr_second);
        step(1);
        chk("ord_idle_valid", {7'd0, bus.valid}, 8'd0);
        chk("ord_idle_pend",  bus.pend, 8'h00);
        bus.ready = 1'b0;
        bus.req_n = 8'hFF;
        step(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
